// File: rtl/vga_frame_monitor_if.sv
// Pixel-stream bundle carried between draw stages and toward the VGA pins.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_frame_monitor.sv
// Passive per-frame monitor of a vga_if stream: geometry check, rgb checksum and
// an optional colour probe enabled by the VGA_MON_PROBE_EN macro.
module vga_frame_monitor #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned PROBE_X  = 400,
    parameter int unsigned PROBE_Y  = 300
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [10:0] line_count,
    output logic        frame_ok,
    output logic        err_sticky,
    output logic [11:0] probe_rgb,
    output logic [15:0] frame_count
);
    localparam int unsigned CW = 11;
    localparam int unsigned SW = 16;
    localparam int unsigned RW = 12;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {SYNC, ACTIVE, BLANK} state_t;

    state_t        state;
    logic          s_hblnk, s_vblnk, p_hblnk, p_vblnk;
    logic [RW-1:0] s_rgb;
    logic [SW-1:0] acc_sum;
    logic [CW-1:0] pix_cnt, line_cnt;
    logic          err;
    logic          unused_in;

    logic          active_pix, v_fall, v_rise, h_rise, line_evt;
    logic          frame_start, frame_end;
    logic [CW-1:0] line_cnt_nx;
    logic          err_nx, ok_nx;

    // Sample stage plus one-cycle history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_hblnk <= 1'b0;
            s_vblnk <= 1'b0;
            p_hblnk <= 1'b0;
            p_vblnk <= 1'b0;
            s_rgb   <= '0;
        end else begin
            s_hblnk <= vga_in.hblnk;
            s_vblnk <= vga_in.vblnk;
            p_hblnk <= s_hblnk;
            p_vblnk <= s_vblnk;
            s_rgb   <= vga_in.rgb;
        end
    end

    // Line closure is folded in before publish so a line ending with vblnk still counts
    always_comb begin
        active_pix  = !s_hblnk && !s_vblnk;
        v_fall      = p_vblnk && !s_vblnk;
        v_rise      = !p_vblnk && s_vblnk;
        h_rise      = !p_hblnk && s_hblnk;
        line_evt    = h_rise && (!s_vblnk || v_rise);
        frame_start = (state != ACTIVE) && v_fall;
        frame_end   = (state == ACTIVE) && v_rise;
        line_cnt_nx = line_cnt;
        err_nx      = err;
        if (line_evt) begin
            if (pix_cnt != '0 && line_cnt != CNT_MAX)
                line_cnt_nx = line_cnt + 1'b1;
            if (pix_cnt != CW'(H_ACTIVE))
                err_nx = 1'b1;
        end
        ok_nx = !err_nx && (line_cnt_nx == CW'(V_ACTIVE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SYNC;
            acc_sum     <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            err         <= 1'b0;
            frame_done  <= 1'b0;
            frame_sum   <= '0;
            line_count  <= '0;
            frame_ok    <= 1'b0;
            err_sticky  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                SYNC, BLANK: begin
                    // The first pixel of a frame arrives together with the vblnk fall
                    if (v_fall) begin
                        state    <= ACTIVE;
                        acc_sum  <= active_pix ? SW'(s_rgb) : '0;
                        pix_cnt  <= CW'(active_pix);
                        line_cnt <= '0;
                        err      <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (active_pix) begin
                        acc_sum <= acc_sum + SW'(s_rgb);
                        if (pix_cnt != CNT_MAX)
                            pix_cnt <= pix_cnt + 1'b1;
                    end
                    if (line_evt)
                        pix_cnt <= '0;
                    line_cnt <= line_cnt_nx;
                    err      <= err_nx;
                    if (v_rise) begin
                        state       <= BLANK;
                        frame_done  <= 1'b1;
                        frame_sum   <= acc_sum;
                        line_count  <= line_cnt_nx;
                        frame_ok    <= ok_nx;
                        err_sticky  <= err_sticky | !ok_nx;
                        frame_count <= frame_count + 1'b1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

`ifdef VGA_MON_PROBE_EN
    logic [CW-1:0] s_hcount, s_vcount;
    logic [RW-1:0] probe_hold;
    logic          probe_hit;

    assign unused_in = ^{vga_in.hsync, vga_in.vsync};
    assign probe_hit = active_pix && (s_hcount == CW'(PROBE_X)) && (s_vcount == CW'(PROBE_Y));

    // Probe colour is held through the frame and published with the other results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_hcount   <= '0;
            s_vcount   <= '0;
            probe_hold <= '0;
            probe_rgb  <= '0;
        end else begin
            s_hcount <= vga_in.hcount;
            s_vcount <= vga_in.vcount;
            if (frame_start)
                probe_hold <= probe_hit ? s_rgb : '0;
            else if (state == ACTIVE && probe_hit)
                probe_hold <= s_rgb;
            if (frame_end)
                probe_rgb <= probe_hold;
        end
    end
`else
    assign unused_in = ^{vga_in.hsync, vga_in.vsync, vga_in.hcount, vga_in.vcount};
    assign probe_rgb = '0;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Self-checking bench for vga_frame_monitor on a reduced 16x12 frame geometry.
module tb_vga_frame_monitor;
    localparam int H    = 16;
    localparam int V    = 12;
    localparam int PX   = 5;
    localparam int PY   = 7;
    localparam int HT   = H + 4;
    localparam int VB   = 3;
    localparam int MAXL = 16;
`ifdef VGA_MON_PROBE_EN
    localparam bit PROBE_EN = 1'b1;
`else
    localparam bit PROBE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_done, frame_ok, err_sticky;
    logic [15:0] frame_sum, frame_count;
    logic [10:0] line_count;
    logic [11:0] probe_rgb;

    always #5 clk = ~clk;

    vga_if vif();

    vga_frame_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .PROBE_X(PX), .PROBE_Y(PY)) dut (
        .clk         (clk),
        .rst         (rst),
        .vga_in      (vif),
        .frame_done  (frame_done),
        .frame_sum   (frame_sum),
        .line_count  (line_count),
        .frame_ok    (frame_ok),
        .err_sticky  (err_sticky),
        .probe_rgb   (probe_rgb),
        .frame_count (frame_count)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int vr_cyc = 0;

    int          line_len[MAXL];
    logic [11:0] pix[MAXL][HT];

    logic [15:0] exp_count  = '0;
    logic        exp_sticky = 1'b0;

    typedef struct {
        int          cyc;
        logic [15:0] sum;
        logic [10:0] lines;
        logic        ok;
        logic        sticky;
        logic [15:0] count;
        logic [11:0] probe;
    } cap_t;
    cap_t cap_q[$];

    typedef struct {
        logic [11:0] colour;
        bit          spot;
        int          short_line;
        int          short_len;
        int          nl;
        bit          simul;
        logic [15:0] e_sum;
        logic [10:0] e_lines;
        bit          e_ok;
        bit          e_sticky;
        logic [15:0] e_count;
        logic [11:0] e_probe;
    } vec_t;
    vec_t vecs[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Publish watcher: records every strobe and checks it lasts one cycle
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (frame_done) begin
            cap_t c;
            c.cyc = cyc; c.sum = frame_sum; c.lines = line_count; c.ok = frame_ok;
            c.sticky = err_sticky; c.count = frame_count; c.probe = probe_rgb;
            cap_q.push_back(c);
            n_chk++;
            if (prev_done) begin
                n_fail++;
                $display("FAIL done_width: frame_done high on consecutive cycles at %0d", cyc);
            end
        end
        prev_done = frame_done;
    end

    task automatic check_zero(input string tag);
        check({tag, "_done"},   32'(frame_done),  32'd0);
        check({tag, "_sum"},    32'(frame_sum),   32'd0);
        check({tag, "_lines"},  32'(line_count),  32'd0);
        check({tag, "_ok"},     32'(frame_ok),    32'd0);
        check({tag, "_sticky"}, 32'(err_sticky),  32'd0);
        check({tag, "_probe"},  32'(probe_rgb),   32'd0);
        check({tag, "_count"},  32'(frame_count), 32'd0);
    endtask

    task automatic build(input logic [11:0] colour, input bit spot, input int sl, input int slen);
        for (int v = 0; v < MAXL; v++) begin
            line_len[v] = H;
            for (int h = 0; h < HT; h++) pix[v][h] = spot ? 12'h000 : colour;
        end
        if (spot) pix[PY][PX] = 12'hFF0;
        if (sl >= 0) line_len[sl] = slen;
    endtask

    task automatic build_random();
        for (int v = 0; v < MAXL; v++) begin
            line_len[v] = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, H + 2)) : H;
            for (int h = 0; h < HT; h++) pix[v][h] = 12'($urandom);
        end
    endtask

    // Reference: results follow directly from the per-line lengths and pixel array
    function automatic void model(input int nl, output logic [15:0] sum, output logic [10:0] lines,
                                  output logic ok, output logic [11:0] probe);
        int unsigned total = 0;
        int n = 0;
        bit bad = 1'b0;
        probe = 12'h000;
        for (int v = 0; v < nl; v++) begin
            for (int h = 0; h < line_len[v]; h++) total += 32'(pix[v][h]);
            if (line_len[v] > 0) begin
                n++;
                if (line_len[v] != H) bad = 1'b1;
            end
            if (v == PY && PX < line_len[v]) probe = pix[v][PX];
        end
        sum   = 16'(total % 65536);
        lines = 11'(n);
        ok    = !bad && (n == V);
    endfunction

    task automatic drive_frame(input int nl, input bit simul, input int rst_on, input int rst_off);
        bit vr_seen = 1'b0;
        for (int v = 0; v < nl; v++) begin
            for (int h = 0; h < HT; h++) begin
                @(negedge clk);
                if (h == 0 && v == rst_off) rst = 1'b0;
                if (h == 0 && v == rst_on) begin
                    rst = 1'b1;
                    #1;
                    check_zero("rst_mid");
                end
                vif.hcount = 11'(h);
                vif.vcount = 11'(v);
                vif.hsync  = (h == H + 1);
                vif.vsync  = 1'b0;
                vif.hblnk  = (h >= line_len[v]);
                vif.vblnk  = simul && (v == nl - 1) && (h >= line_len[v]);
                vif.rgb    = vif.hblnk ? 12'h000 : pix[v][h];
                if (vif.vblnk && !vr_seen) begin
                    vr_seen = 1'b1;
                    vr_cyc  = cyc;
                end
            end
        end
        for (int l = 0; l < VB; l++) begin
            for (int h = 0; h < HT; h++) begin
                @(negedge clk);
                vif.hcount = 11'(h);
                vif.vcount = 11'(nl + l);
                vif.hsync  = (h == H + 1);
                vif.vsync  = (l == 1);
                vif.hblnk  = (h >= H);
                vif.vblnk  = 1'b1;
                vif.rgb    = 12'h000;
                if (!vr_seen) begin
                    vr_seen = 1'b1;
                    vr_cyc  = cyc;
                end
            end
        end
    endtask

    task automatic expect_frame(input string tag, input logic [15:0] s, input logic [10:0] l,
                                input logic ok, input logic st, input logic [15:0] cnt,
                                input logic [11:0] p);
        cap_t c;
        check({tag, "_done_cnt"}, 32'(cap_q.size()), 32'd1);
        if (cap_q.size() > 0) begin
            c = cap_q.pop_front();
            check({tag, "_latency"}, 32'(c.cyc), 32'(vr_cyc + 2));
            check({tag, "_sum"},     32'(c.sum),    32'(s));
            check({tag, "_lines"},   32'(c.lines),  32'(l));
            check({tag, "_ok"},      32'(c.ok),     32'(ok));
            check({tag, "_sticky"},  32'(c.sticky), 32'(st));
            check({tag, "_count"},   32'(c.count),  32'(cnt));
            check({tag, "_probe"},   32'(c.probe),  32'(p));
        end
        cap_q.delete();
        check({tag, "_hold_sum"},   32'(frame_sum),   32'(s));
        check({tag, "_hold_count"}, 32'(frame_count), 32'(cnt));
    endtask

    task automatic run_model_frame(input string tag, input int nl, input bit simul);
        logic [15:0] s;
        logic [10:0] l;
        logic        ok;
        logic [11:0] p;
        model(nl, s, l, ok, p);
        exp_count  = exp_count + 16'd1;
        exp_sticky = exp_sticky | !ok;
        drive_frame(nl, simul, -1, -1);
        expect_frame(tag, s, l, ok, exp_sticky, exp_count, PROBE_EN ? p : 12'h000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            colour  spot  sl  slen nl    simul sum       lines   ok    sticky cnt    probe
        vecs[0] = '{12'h00F, 1'b0, -1, 0,  V,     1'b0, 16'h0B40, 11'd12, 1'b1, 1'b0, 16'd1, 12'h00F};
        vecs[1] = '{12'h000, 1'b1, -1, 0,  V,     1'b0, 16'h0FF0, 11'd12, 1'b1, 1'b0, 16'd2, 12'hFF0};
        vecs[2] = '{12'h001, 1'b0, 10, 15, V,     1'b0, 16'h00BF, 11'd12, 1'b0, 1'b1, 16'd3, 12'h001};
        vecs[3] = '{12'h00F, 1'b0, -1, 0,  V,     1'b0, 16'h0B40, 11'd12, 1'b1, 1'b1, 16'd4, 12'h00F};
        vecs[4] = '{12'h00F, 1'b0, -1, 0,  V - 1, 1'b0, 16'h0A50, 11'd11, 1'b0, 1'b1, 16'd5, 12'h00F};
        vecs[5] = '{12'h00F, 1'b0, -1, 0,  V,     1'b1, 16'h0B40, 11'd12, 1'b1, 1'b1, 16'd6, 12'h00F};
        vecs[6] = '{12'hFFF, 1'b0, -1, 0,  V,     1'b0, 16'hFF40, 11'd12, 1'b1, 1'b1, 16'd7, 12'hFFF};
        vecs[7] = '{12'h00F, 1'b0, PY, PX, V,     1'b0, 16'h0A9B, 11'd12, 1'b0, 1'b1, 16'd8, 12'h000};

        vif.hcount = '0; vif.vcount = '0; vif.hsync = 1'b0; vif.vsync = 1'b0;
        vif.hblnk = 1'b1; vif.vblnk = 1'b1; vif.rgb = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            build(vecs[i].colour, vecs[i].spot, vecs[i].short_line, vecs[i].short_len);
            drive_frame(vecs[i].nl, vecs[i].simul, -1, -1);
            expect_frame($sformatf("vec%0d", i), vecs[i].e_sum, vecs[i].e_lines, vecs[i].e_ok,
                         vecs[i].e_sticky, vecs[i].e_count, PROBE_EN ? vecs[i].e_probe : 12'h000);
        end

        // Reset held into the middle of a frame: that frame must not publish
        build(12'h00F, 1'b0, -1, 0);
        drive_frame(V, 1'b0, 0, 6);
        check("r1_no_done", 32'(cap_q.size()), 32'd0);
        check("r1_count",   32'(frame_count),  32'd0);
        cap_q.delete();
        exp_count = '0;
        exp_sticky = 1'b0;
        run_model_frame("r1_f1", V, 1'b0);
        run_model_frame("r1_f2", V, 1'b0);

        // Reset pulse during a frame clears all published results at once
        drive_frame(V, 1'b0, 6, 8);
        check("r2_no_done", 32'(cap_q.size()), 32'd0);
        cap_q.delete();
        exp_count = '0;
        exp_sticky = 1'b0;

        for (int i = 0; i < 8; i++) begin
            int nl;
            nl = V - 1 + int'($urandom_range(0, 2));
            build_random();
            run_model_frame($sformatf("rnd%0d", i), nl, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

- Passive sink at the far end of the `vga_if` pixel stream.
- Tap point: after the last draw stage, e.g. after the "player won" overlay, before the VGA pins.
- Per frame, it:
  - checks active-region geometry against configured dimensions;
  - accumulates a 16-bit additive checksum of displayed `rgb`;
  - optionally captures the colour at one probe coordinate.
- Results are published once per frame with a one-cycle strobe, for on-board self-test and simulation scoreboards.

## Interface
- `H_ACTIVE`, default `HOR_PIXELS` (800): expected active pixels per line.
- `V_ACTIVE`, default `VER_PIXELS` (600): expected active lines per frame.
- `PROBE_X`, default 400: probe column, compared against `hcount`.
- `PROBE_Y`, default 300: probe row, compared against `vcount`.
- `clk` — in — 1 — pixel clock.
- `rst` — in — 1 — asynchronous, active-high reset.
- `vga_in` — `vga_if.in` — bundle — monitored stream (`hcount`, `vcount`, `hsync`, `vsync`, `hblnk`, `vblnk`, `rgb`).
- `frame_done` — out — 1 — one-cycle strobe; all frame results valid and updated.
- `frame_sum` — out — 16 — checksum of last complete frame.
- `line_count` — out — 11 — active lines counted in last complete frame.
- `frame_ok` — out — 1 — last frame had correct geometry.
- `err_sticky` — out — 1 — any geometry error since reset.
- `probe_rgb` — out — 12 — `rgb` at (`PROBE_X`, `PROBE_Y`) in last complete frame.
- `frame_count` — out — 16 — completed frames since reset.

## Operation
**Sampling**
- All `vga_in` fields are registered once into a sample stage (`s_*`).
- A second copy `p_hblnk`/`p_vblnk` holds the previous cycle for edge detection.
- Active pixel: `!s_hblnk && !s_vblnk`.

**FSM states**
- `SYNC`: entered from reset. Waits for a `vblnk` falling edge; any partial frame in progress is discarded.
- `ACTIVE`: accumulates the current frame.
- `BLANK`: frame published; waiting for the next frame.

**Transitions**
- `SYNC`/`BLANK` → `ACTIVE` on a `vblnk` falling edge. On that transition, clear `acc_sum`, `pix_cnt`, `line_cnt`, and the frame error flag.
- `ACTIVE` → `BLANK` on a `vblnk` rising edge. On that transition, publish results and pulse `frame_done`.

**In `ACTIVE`**
- Per active pixel:
  - `acc_sum <= acc_sum + {4'b0, s_rgb}`, modulo 2^16 (wraps, no saturation).
  - `pix_cnt++`, 11-bit, saturates at 2047.
- On an `hblnk` rising edge with `s_vblnk == 0`:
  - if `pix_cnt != 0`: `line_cnt++` (11-bit, saturating);
  - if `pix_cnt != H_ACTIVE`: set the frame error flag;
  - clear `pix_cnt` in both cases.
- A line with zero active pixels is not counted.

**Publish** (on `ACTIVE` → `BLANK`)
- `frame_sum <= acc_sum`
- `line_count <= line_cnt`
- `frame_ok <= !err && line_cnt == V_ACTIVE`
- `err_sticky |= !frame_ok_next`
- `frame_count++`, wraps at 2^16.

**Simultaneous events**
- The `hblnk` rise of the last line and the `vblnk` rise can occur on the same cycle. In that case the line check and `line_cnt` increment are applied first, and the published values include that line.

**Other rules**
- `vsync`/`hsync` are ignored; blanking signals alone define the frame.
- No backpressure; the monitor never stalls the stream and has no upstream outputs.

## Timing
- Reset value of every output is 0, including `frame_ok` = 0 and `probe_rgb` = 0. The FSM resets to `SYNC`.
- Assertion of `rst` mid-frame returns the FSM to `SYNC` asynchronously. The next published frame is the first one that starts after reset release.
- Input to sample register: 1 cycle. Edge detection uses sample vs previous sample.
- `frame_done` is high for exactly one cycle, the cycle after the sample stage first holds `vblnk = 1` following an active frame, i.e. 2 clocks after `vblnk` rises at the input.
- All published outputs change on that same edge and hold until the next `frame_done`.
- Minimum frame spacing: 1 blank cycle. Back-to-back frames are published independently.

## Configuration
- `VGA_MON_PROBE_EN` defined:
  - at an active pixel with `s_hcount == PROBE_X && s_vcount == PROBE_Y`, capture `s_rgb` into `probe_hold`;
  - `probe_rgb <= probe_hold` at publish.
  - If the coordinate is never hit in a frame, `probe_rgb` publishes `12'h000`; `probe_hold` clears on frame start.
- `VGA_MON_PROBE_EN` undefined: no probe logic; `probe_rgb` tied to `12'h000`.

## Test plan
- 800×600 frame, all active pixels `12'h00F` → `frame_done` one cycle, `frame_sum = 16'hDD00`, `line_count = 600`, `frame_ok = 1`, `err_sticky = 0`, `frame_count = 1`.
- Same frame with `rgb = 12'hFF0` only at (400,300), black elsewhere, `VGA_MON_PROBE_EN` on → `probe_rgb = 12'hFF0`, `frame_sum = 16'h0FF0`. With the macro off → `probe_rgb = 12'h000`.
- Frame with line 10 shortened to 799 active pixels → `frame_ok = 0`, `err_sticky = 1`. Next correct frame → `frame_ok = 1`, `err_sticky` stays 1.
- Frame with 599 active lines → `line_count = 599`, `frame_ok = 0`.
- Release reset mid-frame (line 300), then 2 full frames → first `frame_done` only after the first complete frame, `frame_count = 1`, then 2. Assert `rst` during the second frame → all outputs 0 immediately.
- Last line's `hblnk` and `vblnk` rising on the same cycle → `line_count = 600`, `frame_ok = 1`.
